// File: rtl/nvram_pkg.sv
// nvram_pkg: shared types, constants and lane helper for the high-score save bridge
package nvram_pkg;
  typedef enum logic [1:0] {IDLE, WR, RD, RDLAST} state_t;
  localparam logic [7:0] NVRAM_WINDOW = 8'h20;
  localparam int BEATS = 4;
  // Lane 0 is the most significant byte of a big-endian bridge word
  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] k);
    return w[{~k, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/nvram_bridge.sv
// nvram_bridge: serialises APF bridge words into byte accesses on the save RAM, clipped to nvram_size
module nvram_bridge
  import nvram_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = {NVRAM_WINDOW, 24'h0},
  parameter int AW = 16
) (
  input  logic          clk_74a,
  input  logic          reset,
  input  logic [15:0]   nvram_size,
  input  logic [31:0]   bridge_addr,
  input  logic          bridge_wr,
  input  logic [31:0]   bridge_wr_data,
  input  logic          bridge_rd,
  output logic [31:0]   bridge_rd_data,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr,
  output logic [7:0]    mem_wdata,
  output logic          mem_rd,
  input  logic [7:0]    mem_rdata,
  output logic          busy,
  output logic          overrun,
  input  logic          overrun_clr
);
  localparam int CW = (AW > 16 ? AW : 16) + 1;
  state_t state, state_nx;
  logic [1:0] beat;
  logic [AW-1:0] off;
  logic [31:0] wdata;
  logic [23:0] acc;
  logic cap, cap_v, hit, wr_hit, rd_hit, drop, lane_ok, active;
  logic [CW-1:0] lane_addr;
  logic [7:0] rd_byte;
  logic unused_addr;
  assign unused_addr = ^{bridge_addr[23:AW], bridge_addr[1:0]};
  assign hit = bridge_addr[31:24] == ADDR_BASE[31:24];
  assign wr_hit = hit & bridge_wr;
  assign rd_hit = hit & bridge_rd;
  assign busy = state != IDLE;
  assign active = state == WR || state == RD;
  assign drop = busy ? (wr_hit | rd_hit) : (wr_hit & rd_hit);
  // Widened by one bit so offsets near the top of the RAM clip instead of wrapping
  assign lane_addr = CW'(off) + CW'(beat);
  assign lane_ok = lane_addr < CW'(nvram_size);
  assign rd_byte = cap_v ? mem_rdata : 8'h00;
  always_ff @(posedge clk_74a)
    state <= reset ? IDLE : state_nx;
  always_comb begin
    state_nx = state == IDLE   ? (wr_hit ? WR : rd_hit ? RD : IDLE) :
               state == RDLAST ? IDLE :
               beat == 2'(BEATS - 1) ? (state == RD ? RDLAST : IDLE) : state;
  end
  always_comb begin
    mem_wr    = state == WR && lane_ok;
    mem_rd    = state == RD && lane_ok;
    mem_addr  = active ? lane_addr[AW-1:0] : '0;
    mem_wdata = state == WR ? lane_byte(wdata, beat) : 8'h00;
  end
  always_ff @(posedge clk_74a) begin
    if (reset) begin
      beat           <= 2'd0;
      off            <= '0;
      wdata          <= 32'h0;
      acc            <= 24'h0;
      cap            <= 1'b0;
      cap_v          <= 1'b0;
      bridge_rd_data <= 32'h0;
      overrun        <= 1'b0;
    end else begin
      beat <= active ? beat + 2'd1 : 2'd0;
      if (state == IDLE && (wr_hit || rd_hit)) begin
        off   <= {bridge_addr[AW-1:2], 2'b00};
        wdata <= bridge_wr_data;
      end
      cap   <= state == RD;
      cap_v <= mem_rd;
      if (cap) acc <= {acc[15:0], rd_byte};
      if (state == RDLAST) bridge_rd_data <= {acc, rd_byte};
      overrun <= drop | (overrun & ~overrun_clr);
    end
  end
endmodule
